ps2_key_decoder: RTL and testbench
==================================

// Module: ps2_key_decoder
// PURPOSE
//  Receives PS/2 keyboard frames, tracks make/break (F0) and extended (E0) prefixes,
//  and translates movement keys to ASCII codes on key[7:0].
//  Sits directly upstream of the motion-control host, which consumes key as
//  'w'/'a'/'s'/'d' = 8'h77/8'h61/8'h73/8'h64.
//  Single clk domain; the PS/2 lines are asynchronous inputs synchronised internally.
// PARAMETERS
//  TIMEOUT_CYC  50000  clk cycles without a ps2_clk falling edge before an open frame aborts (1 ms @ 50 MHz)
//  SYNC_STAGES  2      flip-flop stages on ps2_clk and ps2_data (min 2)
// PORTS
//  clk        in   1  system clock; all state updates on its rising edge
//  rst        in   1  asynchronous, active-high reset
//  ps2_clk    in   1  raw PS/2 clock from the keyboard (async)
//  ps2_data   in   1  raw PS/2 data from the keyboard (async)
//  key        out  8  ASCII of the last mapped key event; 8'h00 when no key is held
//  key_valid  out  1  one-cycle pulse on every update of key (make, repeat, release)
//  key_held   out  1  high while a mapped key is pressed
//  frame_err  out  1  one-cycle pulse on a rejected frame (stop/parity error, timeout)
// BEHAVIOUR
//  Reset: key=8'h00, key_valid=0, key_held=0, frame_err=0; FSM=IDLE; bit counter, timeout counter, E0/F0 flags cleared.
//   Reset is asynchronous and aborts any frame in progress immediately.
//  Edge detection: falling edge of the synchronised ps2_clk (prev=1, cur=0); ps2_data sampled in that same cycle.
//  Frame FSM, advanced only on a detected edge:
//   IDLE  : data=0 -> DATA, bit_cnt=0; data=1 -> stay IDLE, no error.
//   DATA  : shift in LSB first; after 8 bits -> PARITY.
//   PARITY: capture the bit -> STOP.
//   STOP  : data=1 -> byte accepted, IDLE; data=0 -> frame_err pulse, byte discarded, IDLE.
//  Timeout: counter clears on every edge and while IDLE.
//   Outside IDLE, reaching TIMEOUT_CYC-1 -> IDLE, frame_err pulse, partial byte dropped.
//   An edge in the same cycle as the timeout wins: counter clears, no abort.
//  Byte layer (runs on an accepted byte):
//   8'hF0 -> set brk; 8'hE0 -> set ext; no output in either case.
//   Any other byte is looked up using the current ext flag; brk and ext then clear.
//   Map, ext=0: 1D->77, 1C->61, 1B->73, 23->64.
//   Map, ext=1: 75->77, 6B->61, 72->73, 74->64 (arrow keys).
//   Anything else is unmapped: ignored, flags still cleared.
//   Make (brk=0), mapped: key<=ascii, key_held<=1, key_valid pulse.
//    A typematic repeat of the same code pulses key_valid again.
//   Break (brk=1), mapped and equal to the current key: key<=8'h00, key_held<=0, key_valid pulse.
//    A break for any other key is ignored.
//  Latency: key/key_valid update 2 clk cycles after the cycle in which the stop-bit edge is detected.
//   frame_err asserts 1 cycle after its detecting cycle.
//  key_valid and frame_err are never high in the same cycle.
// CONFIGURATION
//  PS2_PARITY_CHECK_EN defined: odd parity is checked over data[7:0] plus the parity bit.
//   On mismatch: byte discarded, frame_err pulse, E0/F0 flags left unchanged.
//  PS2_PARITY_CHECK_EN undefined: the parity bit is sampled and ignored; only a bad stop bit or a timeout raises frame_err.
// STRUCTURE
//  Package ps2_pkg:
//   scan-code constants: SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_W/A/S/D, SC_UP/LEFT/DOWN/RIGHT;
//   ASCII constants: ASC_W/A/S/D, ASC_NONE=8'h00;
//   frame-state enum: IDLE/DATA/PARITY/STOP.
//  Sub-module ps2_rx_frame: synchroniser, edge detect, frame FSM, timeout, parity check.
//   Outputs byte[7:0] + byte_stb + err_stb.
//  ps2_key_decoder: instantiates ps2_rx_frame; adds prefix flags, lookup table and output registers.
// TESTING
//  1 Frame 0x1D with correct parity -> key=8'h77, key_valid 1 cycle, key_held=1.
//  2 F0,1D after 1 -> key=8'h00, key_held=0, one key_valid pulse; F0,1C while 'w' held -> no change.
//  3 E0,6B -> key=8'h61; then 0x1D twice -> key=8'h77 with two key_valid pulses.
//  4 Stop bit 0 on frame 0x23 -> frame_err pulse, key unchanged.
//   With PS2_PARITY_CHECK_EN, bad parity on 0x23 -> frame_err, key unchanged.
//  5 Stop ps2_clk after 4 data bits for TIMEOUT_CYC cycles -> frame_err, IDLE.
//   The next full frame 0x1B then gives key=8'h73.
//  6 Assert rst mid-frame -> all outputs 0 immediately; the next frame 0x1C decodes to 8'h61.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared scan-code/ASCII constants, frame-state encoding and helper functions for the PS/2 key decoder.
// Optional feature macro used by this slice: PS2_PARITY_CHECK_EN.
package ps2_pkg;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_D     = 8'h23;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  localparam logic [7:0] ASC_W    = 8'h77;
  localparam logic [7:0] ASC_A    = 8'h61;
  localparam logic [7:0] ASC_S    = 8'h73;
  localparam logic [7:0] ASC_D    = 8'h64;
  localparam logic [7:0] ASC_NONE = 8'h00;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  // PS/2 uses odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

  // Returns {hit, ascii}; arrow keys alias WASD when the E0 prefix was seen.
  function automatic logic [8:0] key_lookup(input logic [7:0] code, input logic ext);
    logic [8:0] res;
    res = {1'b0, ASC_NONE};
    if (ext) begin
      case (code)
        SC_UP:    res = {1'b1, ASC_W};
        SC_LEFT:  res = {1'b1, ASC_A};
        SC_DOWN:  res = {1'b1, ASC_S};
        SC_RIGHT: res = {1'b1, ASC_D};
        default:  res = {1'b0, ASC_NONE};
      endcase
    end else begin
      case (code)
        SC_W:    res = {1'b1, ASC_W};
        SC_A:    res = {1'b1, ASC_A};
        SC_S:    res = {1'b1, ASC_S};
        SC_D:    res = {1'b1, ASC_D};
        default: res = {1'b0, ASC_NONE};
      endcase
    end
    return res;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 frame receiver: line synchronisers, falling-edge detect, frame FSM and inactivity timeout.
// With PS2_PARITY_CHECK_EN defined, frames with bad odd parity are rejected.
module ps2_rx_frame #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_stb,
  output logic       err_stb
);
  import ps2_pkg::*;

  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [SYNC_STAGES-1:0] clk_sync_r;
  logic [SYNC_STAGES-1:0] data_sync_r;
  logic                   clk_prev_r;
  logic [1:0]             state_r;
  logic [2:0]             bit_cnt_r;
  logic [7:0]             shift_r;
  logic [CW-1:0]          to_cnt_r;
  logic                   fall_s;
  logic                   data_s;
  logic                   timeout_s;
  logic                   accept_s;
`ifdef PS2_PARITY_CHECK_EN
  logic                   par_r;
`endif

  // Synchronise both lines; idle-high reset value prevents a spurious edge after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_r  <= {SYNC_STAGES{1'b1}};
      data_sync_r <= {SYNC_STAGES{1'b1}};
      clk_prev_r  <= 1'b1;
    end else begin
      clk_sync_r  <= {clk_sync_r[SYNC_STAGES-2:0], ps2_clk};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], ps2_data};
      clk_prev_r  <= clk_sync_r[SYNC_STAGES-1];
    end
  end

  // Edge, timeout and stop-bit acceptance decode; an edge always beats the timeout.
  always_comb begin
    fall_s    = clk_prev_r & ~clk_sync_r[SYNC_STAGES-1];
    data_s    = data_sync_r[SYNC_STAGES-1];
    timeout_s = (state_r != IDLE) && !fall_s && (to_cnt_r == CW'(TIMEOUT_CYC - 1));
`ifdef PS2_PARITY_CHECK_EN
    accept_s  = data_s && odd_parity_ok(shift_r, par_r);
`else
    accept_s  = data_s;
`endif
  end

  // Inactivity counter: runs only inside an open frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_r <= {CW{1'b0}};
    end else if (fall_s || state_r == IDLE || timeout_s) begin
      to_cnt_r <= {CW{1'b0}};
    end else begin
      to_cnt_r <= to_cnt_r + CW'(1);
    end
  end

  // Frame FSM, advanced only on a detected ps2_clk falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      rx_byte   <= 8'h00;
      byte_stb  <= 1'b0;
      err_stb   <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_r     <= 1'b0;
`endif
    end else begin
      byte_stb <= 1'b0;
      err_stb  <= 1'b0;
      if (timeout_s) begin
        state_r <= IDLE;
        err_stb <= 1'b1;
      end else if (fall_s) begin
        case (state_r)
          IDLE: begin
            if (!data_s) begin
              state_r   <= DATA;
              bit_cnt_r <= 3'd0;
            end
          end
          DATA: begin
            shift_r <= {data_s, shift_r[7:1]};
            if (bit_cnt_r == 3'd7) begin
              state_r <= PARITY;
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            par_r <= data_s;
`endif
            state_r <= STOP;
          end
          STOP: begin
            state_r <= IDLE;
            if (accept_s) begin
              rx_byte  <= shift_r;
              byte_stb <= 1'b1;
            end else begin
              err_stb <= 1'b1;
            end
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard decoder: tracks E0/F0 prefixes and maps WASD/arrow keys to ASCII for the motion host.
// Optional odd-parity rejection is enabled with PS2_PARITY_CHECK_EN.
module ps2_key_decoder #(
  parameter int TIMEOUT_CYC = 50000,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] key,
  output logic       key_valid,
  output logic       key_held,
  output logic       frame_err
);
  import ps2_pkg::*;

  logic [7:0] rx_byte_s;
  logic       byte_stb_s;
  logic       err_stb_s;
  logic       brk_r;
  logic       ext_r;
  logic [8:0] lookup_s;
  logic       hit_s;
  logic [7:0] asc_s;

  ps2_rx_frame #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx_byte  (rx_byte_s),
    .byte_stb (byte_stb_s),
    .err_stb  (err_stb_s)
  );

  // Error strobe is already a register in the receiver, one cycle after detection.
  assign frame_err = err_stb_s;

  // Table lookup qualified by the extended-prefix flag.
  always_comb begin
    lookup_s = key_lookup(rx_byte_s, ext_r);
    hit_s    = lookup_s[8];
    asc_s    = lookup_s[7:0];
  end

  // Prefix flags and key output registers, updated on each accepted byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk_r     <= 1'b0;
      ext_r     <= 1'b0;
      key       <= ASC_NONE;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (byte_stb_s) begin
        if (rx_byte_s == SC_BREAK) begin
          brk_r <= 1'b1;
        end else if (rx_byte_s == SC_EXT) begin
          ext_r <= 1'b1;
        end else begin
          brk_r <= 1'b0;
          ext_r <= 1'b0;
          if (hit_s && !brk_r) begin
            key       <= asc_s;
            key_held  <= 1'b1;
            key_valid <= 1'b1;
          end else if (hit_s && asc_s == key) begin
            // Release only counts for the key currently reported as held.
            key       <= ASC_NONE;
            key_held  <= 1'b0;
            key_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed cases plus randomized scan-code streams
// checked against a table-driven model of the key-event rules.
module tb_ps2_key_decoder;

  localparam int TO   = 300;
  localparam int HALF = 8;
  localparam int GAP  = 30;

  typedef struct {
    bit         is_err;
    logic [7:0] key;
    bit         held;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] key;
  logic       key_valid;
  logic       key_held;
  logic       frame_err;

  int   checks;
  int   errors;
  ev_t  exp_q[$];

  // reference model state
  logic [7:0] m_key;
  bit         m_brk;
  bit         m_ext;
  int         amap[int];

  ps2_key_decoder #(.TIMEOUT_CYC(TO), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .key       (key),
    .key_valid (key_valid),
    .key_held  (key_held),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: one received byte (or rejected frame) -> expected output events
  task automatic model_byte(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    int idx;
    logic [7:0] a;
    if (stop_bad) begin
      exp_q.push_back('{1'b1, 8'h00, 1'b0});
      return;
    end
`ifdef PS2_PARITY_CHECK_EN
    if (par_bad) begin
      exp_q.push_back('{1'b1, 8'h00, 1'b0});
      return;
    end
`endif
    if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else begin
      idx = {23'd0, m_ext, b};
      if (amap.exists(idx)) begin
        a = amap[idx][7:0];
        if (!m_brk) begin
          m_key = a;
          exp_q.push_back('{1'b0, a, 1'b1});
        end else if (a == m_key) begin
          m_key = 8'h00;
          exp_q.push_back('{1'b0, 8'h00, 1'b0});
        end
      end
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
  endtask

  task automatic ps2_bit(input logic d);
    ps2_data = d;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    logic [10:0] bits;
    model_byte(b, par_bad, stop_bad);
    bits = {~stop_bad, (~^b) ^ par_bad, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
    ps2_data = 1'b1;
    repeat (GAP) @(negedge clk);
  endtask

  task automatic chk_state(input string nm);
    checks++;
    if (key !== m_key || key_held !== (m_key != 8'h00)) begin
      errors++;
      $display("FAIL %s: key=%h held=%b, expected key=%h held=%b", nm, key, key_held, m_key, (m_key != 8'h00));
    end
  endtask

  task automatic chk_zero(input string nm);
    checks++;
    if (key !== 8'h00 || key_valid !== 1'b0 || key_held !== 1'b0 || frame_err !== 1'b0) begin
      errors++;
      $display("FAIL %s: key=%h valid=%b held=%b err=%b, expected all zero", nm, key, key_valid, key_held, frame_err);
    end
  endtask

  // monitor: pop one expectation per output pulse
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      if (!rst && (key_valid || frame_err)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event: key_valid=%b frame_err=%b key=%h, expected no event", key_valid, frame_err, key);
        end else begin
          e = exp_q.pop_front();
          if (key_valid && frame_err) begin
            errors++;
            $display("FAIL both_pulses: key_valid=1 frame_err=1, expected only one");
          end else if (e.is_err && !frame_err) begin
            errors++;
            $display("FAIL err_event: got key_valid key=%h, expected frame_err", key);
          end else if (!e.is_err && (!key_valid || key !== e.key || key_held !== e.held)) begin
            errors++;
            $display("FAIL key_event: valid=%b key=%h held=%b, expected valid=1 key=%h held=%b",
                     key_valid, key, key_held, e.key, e.held);
          end
        end
      end
    end
  end

  initial begin
    logic [7:0] pool [15];
    logic [7:0] b;
    int r;
    int wait_cyc;
    pool = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h72, 8'h74,
             8'hF0, 8'hE0, 8'hF0, 8'hE0, 8'h12, 8'h5A, 8'h1D};
    amap[32'h01D] = 32'h77; amap[32'h01C] = 32'h61; amap[32'h01B] = 32'h73; amap[32'h023] = 32'h64;
    amap[32'h175] = 32'h77; amap[32'h16B] = 32'h61; amap[32'h172] = 32'h73; amap[32'h174] = 32'h64;
    checks = 0; errors = 0;
    m_key = 8'h00; m_brk = 1'b0; m_ext = 1'b0;
    rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 1: make 'w'
    send_frame(8'h1D, 1'b0, 1'b0);  chk_state("make_w");
    // 2: break 'w', then break of an unheld key while 'w' held
    send_frame(8'hF0, 1'b0, 1'b0);  send_frame(8'h1D, 1'b0, 1'b0);  chk_state("break_w");
    send_frame(8'h1D, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);  send_frame(8'h1C, 1'b0, 1'b0);  chk_state("break_other");
    // 3: arrow left, then typematic 'w'
    send_frame(8'hE0, 1'b0, 1'b0);  send_frame(8'h6B, 1'b0, 1'b0);  chk_state("ext_left");
    send_frame(8'h1D, 1'b0, 1'b0);  send_frame(8'h1D, 1'b0, 1'b0);  chk_state("repeat_w");
    // 4: bad stop bit, bad parity
    send_frame(8'h23, 1'b0, 1'b1);  chk_state("bad_stop");
    send_frame(8'h23, 1'b1, 1'b0);  chk_state("bad_parity");
    // 5: timeout after 4 data bits, then a clean 's'
    exp_q.push_back('{1'b1, 8'h00, 1'b0});
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(b[0] ^ 1'b1);
    ps2_data = 1'b1;
    repeat (TO + 40) @(negedge clk);
    send_frame(8'h1B, 1'b0, 1'b0);  chk_state("after_timeout");
    // 6: async reset mid-frame
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 chk_zero("async_reset");
    exp_q.delete();
    m_key = 8'h00; m_brk = 1'b0; m_ext = 1'b0;
    ps2_clk = 1'b1; ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    send_frame(8'h1C, 1'b0, 1'b0);  chk_state("after_reset");

    // randomized stream
    for (int n = 0; n < 80; n++) begin
      b = pool[$urandom_range(0, 14)];
      r = $urandom_range(0, 11);
      send_frame(b, r == 1, r == 0);
    end
    chk_state("random_end");

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 500) begin
      @(negedge clk);
      wait_cyc++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected events never seen, expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
